// File: rtl/char_fetch_pkg.sv
// Shared constants for the text-frame character fetcher: machine word size
// and the display geometry and FSM states used by char_fetch.
package gc;
  localparam int WORD_SIZE = 32;
endpackage

package char_fetch_pkg;
  localparam int ASCII_SIZE      = 8;
  localparam int CHARS_HORZ      = 80;
  localparam int CHARS_VERT      = 30;
  localparam int CHARS_PER_FRAME = CHARS_HORZ * CHARS_VERT;
  localparam int CHARS_PER_WORD  = gc::WORD_SIZE / ASCII_SIZE;
  localparam int WORDS_PER_FRAME = CHARS_PER_FRAME / CHARS_PER_WORD;
  localparam int CHR_ADDR_W      = 12;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_FRAME);
  localparam int LANE_W          = $clog2(CHARS_PER_WORD);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UNPACK} fetch_state_t;
endpackage

// File: rtl/char_fetch_word_unpacker.sv
// Holds one fetched memory word and presents its characters MSB-first,
// one lane per advance.
module word_unpacker
  import char_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     advance,
  input  logic [gc::WORD_SIZE-1:0] word,
  output logic [ASCII_SIZE-1:0]    chr,
  output logic                     last
);
  logic [gc::WORD_SIZE-1:0] word_q;
  logic [gc::WORD_SIZE-1:0] shifted;
  logic [LANE_W-1:0]        lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      lane   <= '0;
    end else if (load) begin
      word_q <= word;
      lane   <= '0;
    end else if (advance) begin
      lane <= lane + 1'b1;
    end
  end

  // lane 0 is the most significant character of the word
  assign shifted = word_q << (lane * ASCII_SIZE);
  assign chr     = shifted[gc::WORD_SIZE-1 -: ASCII_SIZE];
  assign last    = (lane == LANE_W'(CHARS_PER_WORD - 1));
endmodule

// File: rtl/char_fetch.sv
// Sweeps the text frame out of main memory one word at a time and streams
// the unpacked characters into the character buffer.
module char_fetch
  import char_fetch_pkg::*;
#(
  parameter logic [gc::WORD_SIZE-1:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  output logic                     mem_req,
  input  logic                     mem_gnt,
  output logic [gc::WORD_SIZE-1:0] mem_addr,
  input  logic [gc::WORD_SIZE-1:0] mem_rdata,
  output logic                     chr_we,
  output logic [CHR_ADDR_W-1:0]    chr_addr,
  output logic [ASCII_SIZE-1:0]    chr_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);
  fetch_state_t            state, state_nxt;
  logic [WORD_IDX_W-1:0]   word_idx;
  logic [CHR_ADDR_W-1:0]   chr_idx, addr_hold;
  logic [ASCII_SIZE-1:0]   chr_lane, data_hold;
  logic                    load, advance, lane_last, last_word, start_ok;

  assign last_word = (word_idx == WORD_IDX_W'(WORDS_PER_FRAME - 1));
  assign start_ok  = frame_start && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = WAIT;
      WAIT:    state_nxt = UNPACK;
      UNPACK:  if (lane_last) state_nxt = last_word ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Character outputs are live during UNPACK and otherwise show the last write.
  always_comb begin
    mem_req    = (state == REQ);
    busy       = (state != IDLE);
    load       = (state == WAIT);
    advance    = (state == UNPACK);
    chr_we     = advance;
    frame_done = advance && lane_last && last_word;
    chr_addr   = advance ? chr_idx  : addr_hold;
    chr_data   = advance ? chr_lane : data_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= BASE_ADDR;
      word_idx  <= '0;
      chr_idx   <= '0;
      addr_hold <= '0;
      data_hold <= '0;
      overrun   <= 1'b0;
    end else begin
      if (start_ok) begin
        word_idx <= '0;
        chr_idx  <= '0;
        mem_addr <= BASE_ADDR;
      end
      if (frame_start && busy) overrun <= 1'b1;
      if (advance) begin
        addr_hold <= chr_idx;
        data_hold <= chr_lane;
        chr_idx   <= chr_idx + 1'b1;
        if (lane_last && !last_word) begin
          word_idx <= word_idx + 1'b1;
          mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

  word_unpacker u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .word    (mem_rdata),
    .chr     (chr_lane),
    .last    (lane_last)
  );
endmodule

// File: tb/tb_char_fetch.sv
// Bench for char_fetch: memory model returning word i = {i, i+1, i+2, i+3}
// (bytes), a write monitor, and a frame-level reference of order/data/timing.
module tb_char_fetch;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] BASE_W = 32'hFFFF_FFF0;

  logic        clk, rst_n, frame_start, mem_gnt, mem_req, chr_we, busy, frame_done, overrun;
  logic [31:0] mem_addr, mem_rdata;
  logic [11:0] chr_addr;
  logic [7:0]  chr_data;

  logic        fs2, gnt2, req2, we2, busy2, done2, ovr2;
  logic [31:0] addr2, rdata2;
  logic [11:0] caddr2;
  logic [7:0]  cdata2;

  int total = 0, bad = 0, cyc = 0, first_bad = -1;
  int wr_t[$], fd_t[$];
  logic [11:0] wr_a[$];
  logic [7:0]  wr_d[$];

  char_fetch dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .chr_we(chr_we), .chr_addr(chr_addr),
    .chr_data(chr_data), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  char_fetch #(.BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .frame_start(fs2), .mem_req(req2), .mem_gnt(gnt2),
    .mem_addr(addr2), .mem_rdata(rdata2), .chr_we(we2), .chr_addr(caddr2),
    .chr_data(cdata2), .busy(busy2), .frame_done(done2), .overrun(ovr2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // memory: data valid in the cycle after the grant cycle
  always @(posedge clk) begin
    mem_rdata <= (mem_req && mem_gnt) ? word_of(int'(mem_addr - BASE)) : 'x;
    rdata2    <= (req2 && gnt2) ? word_of(int'(addr2 - BASE_W)) : 'x;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (chr_we === 1'b1) begin
      wr_t.push_back(cyc);
      wr_a.push_back(chr_addr);
      wr_d.push_back(chr_data);
    end
    if (frame_done === 1'b1) fd_t.push_back(cyc);
  end

  // Reference: write n belongs to word n/4, lane n%4; its data is byte (n/4 + n%4),
  // it lands 3 + 6*word + lane cycles after frame_start plus any grant stall.
  function automatic int bad_writes(int n, int t0, bit chk_t, int sw, int sl);
    int nb = 0;
    first_bad = -1;
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      int w, k, et;
      logic [7:0] ed;
      w  = i / 4;
      k  = i % 4;
      ed = 8'(w + k);
      et = t0 + 3 + 6 * w + k + ((w >= sw) ? sl : 0);
      if (wr_a[i] !== 12'(i) || wr_d[i] !== ed || (chk_t && wr_t[i] !== et)) begin
        nb++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return nb;
  endfunction

  task automatic clear_mon();
    wr_t.delete(); wr_a.delete(); wr_d.delete(); fd_t.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // returns at the negedge of cycle t0+1, where t0 is the frame_start cycle
  task automatic start_frame(output int t0);
    @(negedge clk);
    frame_start = 1;
    t0 = cyc;
    @(negedge clk);
    frame_start = 0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && fd_t.size() == 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    int reqs = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req, mem_addr, chr_we, chr_addr, chr_data, busy, frame_done, overrun} !==
        {1'b0, BASE, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals got req=%b addr=%h we=%b ca=%h cd=%h busy=%b done=%b ovr=%b want 0/%h/0/0/0/0/0/0",
               mem_req, mem_addr, chr_we, chr_addr, chr_data, busy, frame_done, overrun, BASE);
    end
    rst_n = 1;
    repeat (10) begin @(negedge clk); if (mem_req !== 1'b0) reqs++; end
    total++;
    if (reqs !== 0) begin bad++; $display("FAIL idle_no_req got %0d requests want 0", reqs); end
  endtask

  task automatic test_full_frame();
    int t0, nb;
    clear_mon();
    mem_gnt = 1;
    start_frame(t0);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== BASE || busy !== 1'b1) begin
      bad++; $display("FAIL first_req got req=%b addr=%h busy=%b want 1/%h/1", mem_req, mem_addr, busy, BASE);
    end
    wait_done(4000);
    total++;
    if (fd_t.size() !== 1 || fd_t[0] !== t0 + 3600) begin
      bad++; $display("FAIL done_time got n=%0d t=%0d want 1 at %0d", fd_t.size(), fd_t.size() ? fd_t[0] - t0 : -1, 3600);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after got %b want 0", busy); end
    total++;
    if (wr_a.size() !== 2400) begin bad++; $display("FAIL write_count got %0d want 2400", wr_a.size()); end
    nb = bad_writes(2400, t0, 1, 1 << 30, 0);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL write_stream got %0d bad (first %0d) want 0", nb, first_bad); end
    total++;
    if (chr_addr !== 12'd2399 || chr_data !== 8'(599 + 3)) begin
      bad++; $display("FAIL hold_last got %h/%h want 95f/%h", chr_addr, chr_data, 8'(599 + 3));
    end
  endtask

  task automatic test_stall();
    int t0, nb, stalled = 0, stall_bad = 0;
    clear_mon();
    mem_gnt = 1;
    start_frame(t0);
    for (int i = 0; i < 4000 && fd_t.size() == 0; i++) begin
      if (mem_req && mem_addr == BASE + 10 && stalled < 5) begin
        mem_gnt = 0;
        stalled++;
        if (chr_we !== 1'b0) stall_bad++;
      end else begin
        if (stalled > 0 && stalled < 5) stall_bad++;
        mem_gnt = 1;
      end
      if (stalled > 0 && mem_req && mem_addr !== BASE + 10 && !mem_gnt) stall_bad++;
      @(negedge clk);
      if (stalled > 0 && stalled <= 5 && mem_gnt == 0 && (mem_req !== 1'b1 || mem_addr !== BASE + 10)) stall_bad++;
    end
    mem_gnt = 1;
    total++;
    if (stalled !== 5 || stall_bad !== 0) begin
      bad++; $display("FAIL stall_hold got stalled=%0d errs=%0d want 5/0", stalled, stall_bad);
    end
    total++;
    if (fd_t.size() !== 1 || fd_t[0] !== t0 + 3605) begin
      bad++; $display("FAIL stall_done got t=%0d want %0d", fd_t.size() ? fd_t[0] - t0 : -1, 3605);
    end
    nb = bad_writes(2400, t0, 1, 10, 5);
    total++;
    if (nb !== 0 || wr_a.size() !== 2400) begin
      bad++; $display("FAIL stall_stream got %0d bad (first %0d) n=%0d want 0/2400", nb, first_bad, wr_a.size());
    end
  endtask

  task automatic test_overrun();
    int t0, reqs = 0;
    apply_reset();
    clear_mon();
    mem_gnt = 1;
    start_frame(t0);
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got %b want 0", overrun); end
    while (cyc < t0 + 100) @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", overrun); end
    wait_done(4000);
    frame_start = 1;            // lands in the frame_done cycle
    @(negedge clk);
    frame_start = 0;
    total++;
    if (busy !== 1'b0 || fd_t.size() !== 1 || fd_t[0] !== t0 + 3600) begin
      bad++; $display("FAIL ovr_frame got busy=%b done_n=%0d want 0/1 at 3600", busy, fd_t.size());
    end
    repeat (30) begin @(negedge clk); if (mem_req !== 1'b0 || busy !== 1'b0) reqs++; end
    total++;
    if (reqs !== 0 || wr_a.size() !== 2400 || overrun !== 1'b1) begin
      bad++; $display("FAIL no_second_sweep got active=%0d writes=%0d ovr=%b want 0/2400/1", reqs, wr_a.size(), overrun);
    end
  endtask

  task automatic test_reset_mid();
    int t0, reqs = 0;
    apply_reset();
    clear_mon();
    mem_gnt = 1;
    start_frame(t0);
    while (cyc < t0 + 1000) @(negedge clk);
    total++;
    if (chr_we !== 1'b1 || chr_addr !== 12'd665) begin
      bad++; $display("FAIL mid_unpack got we=%b ca=%0d want 1/665", chr_we, chr_addr);
    end
    rst_n = 0;
    #1;
    total++;
    if ({mem_req, mem_addr, chr_we, chr_addr, chr_data, busy, frame_done, overrun} !==
        {1'b0, BASE, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset got req=%b addr=%h we=%b ca=%h cd=%h busy=%b done=%b ovr=%b want all reset",
                      mem_req, mem_addr, chr_we, chr_addr, chr_data, busy, frame_done, overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (20) begin @(negedge clk); if (mem_req !== 1'b0) reqs++; end
    total++;
    if (reqs !== 0) begin bad++; $display("FAIL no_resume got %0d requests want 0", reqs); end
    clear_mon();
    start_frame(t0);
    while (cyc < t0 + 10) @(negedge clk);
    total++;
    if (wr_a.size() !== 6 || bad_writes(6, t0, 1, 1 << 30, 0) !== 0) begin
      bad++; $display("FAIL restart got n=%0d first_addr=%0d want 6 writes from 0", wr_a.size(), wr_a.size() ? wr_a[0] : -1);
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    int xs = 0, abad = 0;
    gnt2 = 1;
    @(negedge clk);
    fs2 = 1;
    @(negedge clk);
    fs2 = 0;
    for (int i = 0; i < 140; i++) begin
      if ($isunknown({req2, addr2, we2, caddr2, cdata2, busy2, done2, ovr2})) xs++;
      if (req2 === 1'b1) seen.push_back(addr2);
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ea;
      ea = BASE_W + 32'(i);
      if (i >= seen.size() || seen[i] !== ea) abad++;
    end
    total++;
    if (abad !== 0 || seen.size() < 20 || seen[16] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr got %0d bad of %0d reqs word16=%h want 0 bad, 00000000",
                      abad, seen.size(), seen.size() > 16 ? seen[16] : 32'hx);
    end
    total++;
    if (xs !== 0) begin bad++; $display("FAIL wrap_no_x got %0d X cycles want 0", xs); end
    apply_reset();
  endtask

  task automatic test_random();
    int t0, stalls = 0, nb;
    apply_reset();
    clear_mon();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    mem_gnt = 1;
    start_frame(t0);
    for (int i = 0; i < 12000 && fd_t.size() == 0; i++) begin
      mem_gnt = ($urandom_range(0, 3) != 0);
      if (mem_req && !mem_gnt) stalls++;
      @(negedge clk);
    end
    mem_gnt = 1;
    total++;
    if (fd_t.size() !== 1 || fd_t[0] !== t0 + 3600 + stalls) begin
      bad++; $display("FAIL rand_done got t=%0d want %0d", fd_t.size() ? fd_t[0] - t0 : -1, 3600 + stalls);
    end
    nb = bad_writes(2400, t0, 0, 0, 0);
    total++;
    if (nb !== 0 || wr_a.size() !== 2400) begin
      bad++; $display("FAIL rand_stream got %0d bad (first %0d) n=%0d want 0/2400", nb, first_bad, wr_a.size());
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL rand_end got busy=%b ovr=%b want 0/0", busy, overrun);
    end
  endtask

  initial begin
    rst_n = 0; frame_start = 0; mem_gnt = 1; fs2 = 0; gnt2 = 1;
    test_reset();
    test_full_frame();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_wrap();
    test_random();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
